// File: rtl/ahb_pkg.sv
// Shared AHB constants and slave state encoding.
// Used by the wait-state slave and its counter.
package ahb_pkg;

    localparam logic HTRANS_IDLE   = 1'b0;
    localparam logic HTRANS_ACTIVE = 1'b1;

    localparam logic HBURST_SINGLE = 1'b0;
    localparam logic HBURST_INCR   = 1'b1;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LAST = 2'd2
    } slv_state_e;

    // Wait cycles for a transfer: burst continuation beats
    // use the burst setting, everything else the first-beat one.
    function automatic logic [CNT_W-1:0] wait_sel(
        input logic             burst,
        input logic [CNT_W-1:0] burst_wait,
        input logic [CNT_W-1:0] first_wait
    );
        return burst ? burst_wait : first_wait;
    endfunction

endpackage

// File: rtl/ahb_wait_counter.sv
// Loadable down-counter with a last-cycle flag.
// Load wins over decrement; decrement saturates at zero.
module ahb_wait_counter
    import ahb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    // Count register: load on a new transfer, else count down.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Last wait cycle; <=1 keeps a stray zero from stalling forever.
    always_comb begin
        o_last = (r_cnt <= W'(1));
    end

endmodule

// File: rtl/ahb_wait_slave.sv
// AHB register-bank slave with programmable wait states.
// Pipelined address/data phases, HREADY-driven stalls.
module ahb_wait_slave
    import ahb_pkg::*;
#(
    parameter int NUM_WORDS   = 16,
    parameter int ADDR_W      = 31,
    parameter int WAIT_STATES = 2,
    parameter int BURST_WAIT  = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL1,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic              HTRANS,
    input  logic              HBURST,
    input  logic [31:0]       HWDATA,
    input  logic              HREADYIN,
    output logic [31:0]       HRDATA,
    output logic              HREADY
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int OFS   = $clog2(WORD_BYTES);

    localparam logic [CNT_W-1:0] C_WS = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] C_BW = CNT_W'(BURST_WAIT);

    slv_state_e r_state;
    slv_state_e w_next;

    logic [IDX_W-1:0] r_idx;
    logic             r_wr;
    logic             r_hist;
    logic [31:0]      r_bank [NUM_WORDS];

    logic             w_accept;
    logic             w_burst;
    logic [CNT_W-1:0] w_load_val;
    logic             w_cnt_last;
    logic             w_hready;
    logic [IDX_W-1:0] w_idx;
    logic             w_unused_addr;

    assign w_idx = HADDR[IDX_W+OFS-1:OFS];

    assign w_unused_addr = ^{HADDR[ADDR_W-1:IDX_W+OFS],
                             HADDR[OFS-1:0]};

    // While stalling, address inputs are ignored outright.
    assign w_accept = HSEL1 & (HTRANS == HTRANS_ACTIVE)
                    & HREADYIN & (r_state != WAIT);

    assign w_burst = (HBURST == HBURST_INCR) & r_hist
                   & (HWRITE == r_wr);

    assign w_load_val = wait_sel(w_burst, C_BW, C_WS);

    ahb_wait_counter #(
        .W (CNT_W)
    ) u_cnt (
        .i_clk      (HCLK),
        .i_rst_n    (HRESETn),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .i_dec      (r_state == WAIT),
        .o_last     (w_cnt_last)
    );

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and HREADY from current state.
    always_comb begin
        w_next   = r_state;
        w_hready = 1'b1;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (w_load_val != '0) ? WAIT : LAST;
                end
            end
            WAIT: begin
                w_hready = 1'b0;
                if (w_cnt_last) begin
                    w_next = LAST;
                end
            end
            LAST: begin
                if (w_accept) begin
                    w_next = (w_load_val != '0) ? WAIT : LAST;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign HREADY = w_hready;

    // Address-phase capture and burst history.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_idx  <= '0;
            r_wr   <= 1'b0;
            r_hist <= 1'b0;
        end else if (w_accept) begin
            r_idx  <= w_idx;
            r_wr   <= HWRITE;
            r_hist <= (HBURST == HBURST_INCR);
        end
    end

    // Register bank; writes commit only at the end of LAST.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_bank[i] <= '0;
            end
        end else if ((r_state == LAST) && r_wr) begin
            r_bank[r_idx] <= HWDATA;
        end
    end

    // Read data is driven only during a read's LAST cycle.
    always_comb begin
        HRDATA = '0;
        if ((r_state == LAST) && !r_wr) begin
            HRDATA = r_bank[r_idx];
        end
    end

endmodule
